// File: rtl/lsu_master.sv
// lsu_master: load/store initiator between the core execute stage and data memory.
// Accepts one byte/half/word access, checks it against the memory's rules
// (read-only word 0, depth limit, alignment), runs a req/ack handshake with
// a bounded wait, and returns extended load data or a store completion.
module lsu_master #(
  parameter int AWIDTH  = 32,
  parameter int ALENGTH = 128,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_signed,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [AWIDTH-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [AWIDTH-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [AWIDTH-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [AWIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CHECK, REQ, RESP} state_t;

  state_t            state;
  logic [CW-1:0]     tcnt;

  // Registered copy of the accepted core request
  logic              we_p0;
  logic [1:0]        size_p0;
  logic              sgn_p0;
  logic [AWIDTH-1:0] addr_p0;
  logic [AWIDTH-1:0] wdata_p0;

  // Byte-lane enables for the access size at the given byte offset
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] ofs);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << ofs;
      2'b01:   be = 4'b0011 << ofs;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate right-justified store data across every lane it may land in
  function automatic logic [AWIDTH-1:0] lane_wdata(input logic [1:0] size,
                                                   input logic [AWIDTH-1:0] data);
    logic [AWIDTH-1:0] w;
    case (size)
      2'b00:   w = {(AWIDTH/8){data[7:0]}};
      2'b01:   w = {(AWIDTH/16){data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

  // Pick the addressed bytes out of the memory word and sign/zero-extend them
  function automatic logic [AWIDTH-1:0] load_extend(input logic [1:0] size,
                                                    input logic sgn,
                                                    input logic [1:0] ofs,
                                                    input logic [AWIDTH-1:0] rdata);
    logic [AWIDTH-1:0]  shifted;
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    logic [AWIDTH-1:0]  r;
    shifted = rdata >> {ofs, 3'b000};
    b8      = shifted[7:0];
    h16     = shifted[15:0];
    case (size)
      2'b00:   r = {{(AWIDTH-8){sgn & b8[7]}}, b8};
      2'b01:   r = {{(AWIDTH-16){sgn & h16[15]}}, h16};
      default: r = shifted;
    endcase
    return r;
  endfunction

  // Memory access rules: legal size, natural alignment, depth, read-only word 0
  function automatic logic is_fault(input logic we, input logic [1:0] size,
                                    input logic [AWIDTH-1:0] addr);
    logic f;
    f = 1'b0;
    if (size == 2'b11)                               f = 1'b1;
    if (size == 2'b01 && addr[0])                    f = 1'b1;
    if (size == 2'b10 && addr[1:0] != 2'b00)         f = 1'b1;
    if ((addr >> 2) >= AWIDTH'(ALENGTH))             f = 1'b1;
    if (we && (addr[AWIDTH-1:2] == '0))              f = 1'b1;
    return f;
  endfunction

  assign cpu_ready = (state == IDLE) && !rst;

  // Capture the core request on accept; pure data, no reset needed
  always_ff @(posedge clk) begin
    if (state == IDLE && cpu_valid) begin
      we_p0    <= cpu_we;
      size_p0  <= cpu_size;
      sgn_p0   <= cpu_signed;
      addr_p0  <= cpu_addr;
      wdata_p0 <= cpu_wdata;
    end
  end

  // Access FSM with registered memory-side and core-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tcnt      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          cpu_done <= 1'b0;
          if (cpu_valid) state <= CHECK;
        end
        CHECK: begin
          if (is_fault(we_p0, size_p0, addr_p0)) begin
            state     <= RESP;
            cpu_done  <= 1'b1;
            cpu_err   <= 1'b1;
            cpu_rdata <= '0;
          end else begin
            state     <= REQ;
            tcnt      <= '0;
            mem_req   <= 1'b1;
            mem_we    <= we_p0;
            mem_addr  <= addr_p0 >> 2;
            mem_be    <= lane_be(size_p0, addr_p0[1:0]);
            mem_wdata <= lane_wdata(size_p0, wdata_p0);
          end
        end
        REQ: begin
          // An ack takes priority, so an ack in the last allowed cycle succeeds
          if (mem_ack) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            cpu_done  <= 1'b1;
            cpu_err   <= 1'b0;
            cpu_rdata <= we_p0 ? '0 : load_extend(size_p0, sgn_p0, addr_p0[1:0], mem_rdata);
          end else if (tcnt == CW'(TIMEOUT - 1)) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            cpu_done  <= 1'b1;
            cpu_err   <= 1'b1;
            cpu_rdata <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RESP: begin
          cpu_done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_master.sv
// Directed testbench for lsu_master: stores, signed/unsigned loads, faults,
// timeout with late ack, and reset in the middle of a memory wait.
module tb_lsu_master;

  logic        clk;
  logic        rst;
  logic        cpu_valid;
  logic        cpu_ready;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic        cpu_signed;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_done;
  logic        cpu_err;
  logic [31:0] cpu_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  // Results of the last access
  int          r_done_cyc;
  int          r_ndone;
  int          r_reqcnt;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_we;

  lsu_master #(.AWIDTH(32), .ALENGTH(128), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_valid  (cpu_valid),
    .cpu_ready  (cpu_ready),
    .cpu_we     (cpu_we),
    .cpu_size   (cpu_size),
    .cpu_signed (cpu_signed),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_done   (cpu_done),
    .cpu_err    (cpu_err),
    .cpu_rdata  (cpu_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one access; memory acks on REQ cycle number ack_at (0 = never).
  // Cycle 1 is the cycle after the accept edge.
  task automatic access(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_at, input logic [31:0] rdata);
    chk("ready_before", 32'(cpu_ready), 32'd1);
    cpu_valid  = 1'b1;
    cpu_we     = we;
    cpu_size   = size;
    cpu_signed = sgn;
    cpu_addr   = addr;
    cpu_wdata  = wdata;
    mem_rdata  = rdata;
    tick();
    cpu_valid  = 1'b0;
    r_done_cyc = 0;
    r_ndone    = 0;
    r_reqcnt   = 0;
    r_err      = 1'b0;
    r_rdata    = '0;
    r_addr     = '0;
    r_be       = '0;
    r_wdata    = '0;
    r_we       = 1'b0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      if (mem_req) begin
        r_reqcnt++;
        if (r_reqcnt == 1) begin
          r_addr  = mem_addr;
          r_be    = mem_be;
          r_wdata = mem_wdata;
          r_we    = mem_we;
        end
      end
      if (cpu_done) begin
        r_ndone++;
        if (r_done_cyc == 0) begin
          r_done_cyc = cyc;
          r_err      = cpu_err;
          r_rdata    = cpu_rdata;
        end
      end
      mem_ack = mem_req && (r_reqcnt == ack_at);
      tick();
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    cpu_valid  = 1'b0;
    cpu_we     = 1'b0;
    cpu_size   = 2'b00;
    cpu_signed = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;

    // Reset state
    tick();
    tick();
    chk("rst_ready",   32'(cpu_ready), 32'd0);
    chk("rst_mem_req", 32'(mem_req),   32'd0);
    chk("rst_mem_be",  32'(mem_be),    32'd0);
    chk("rst_mem_addr", mem_addr,      32'd0);
    chk("rst_done",    32'(cpu_done),  32'd0);
    chk("rst_rdata",   cpu_rdata,      32'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", 32'(cpu_ready), 32'd1);

    // Word store 0xDEADBEEF to 0x10, ack on first REQ cycle
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1, 32'h0);
    chk("wst_done_cyc", 32'(r_done_cyc), 32'd3);
    chk("wst_ndone",    32'(r_ndone),    32'd1);
    chk("wst_err",      32'(r_err),      32'd0);
    chk("wst_addr",     r_addr,          32'd4);
    chk("wst_be",       32'(r_be),       32'hF);
    chk("wst_wdata",    r_wdata,         32'hDEADBEEF);
    chk("wst_we",       32'(r_we),       32'd1);
    chk("wst_reqcnt",   32'(r_reqcnt),   32'd1);

    // Signed byte load from 0x13
    access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1, 32'h80FF_0000);
    chk("lbs_be",       32'(r_be),       32'h8);
    chk("lbs_rdata",    r_rdata,         32'hFFFF_FF80);
    chk("lbs_we",       32'(r_we),       32'd0);
    chk("lbs_done_cyc", 32'(r_done_cyc), 32'd3);

    // Same byte load, zero-extended
    access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1, 32'h80FF_0000);
    chk("lbu_rdata",    r_rdata,         32'h0000_0080);

    // Half store 0x1234 to 0x06, ack on third REQ cycle
    access(1'b1, 2'b01, 1'b0, 32'h06, 32'h0000_1234, 3, 32'h0);
    chk("hst_be",       32'(r_be),       32'hC);
    chk("hst_wdata",    r_wdata,         32'h1234_1234);
    chk("hst_addr",     r_addr,          32'd1);
    chk("hst_done_cyc", 32'(r_done_cyc), 32'd5);
    chk("hst_err",      32'(r_err),      32'd0);

    // Signed half load from 0x02
    access(1'b0, 2'b01, 1'b1, 32'h02, 32'h0, 2, 32'h8001_0000);
    chk("lhs_be",       32'(r_be),       32'hC);
    chk("lhs_rdata",    r_rdata,         32'hFFFF_8001);
    chk("lhs_done_cyc", 32'(r_done_cyc), 32'd4);

    // Fault: store to word 0
    access(1'b1, 2'b10, 1'b0, 32'h0, 32'h5555_5555, 1, 32'h0);
    chk("f0_done_cyc",  32'(r_done_cyc), 32'd2);
    chk("f0_err",       32'(r_err),      32'd1);
    chk("f0_reqcnt",    32'(r_reqcnt),   32'd0);

    // Fault: misaligned word load
    access(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 1, 32'hFFFF_FFFF);
    chk("f1_done_cyc",  32'(r_done_cyc), 32'd2);
    chk("f1_err",       32'(r_err),      32'd1);
    chk("f1_reqcnt",    32'(r_reqcnt),   32'd0);
    chk("f1_rdata",     r_rdata,         32'd0);

    // Fault: word index 128 is out of range
    access(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1, 32'hFFFF_FFFF);
    chk("f2_done_cyc",  32'(r_done_cyc), 32'd2);
    chk("f2_err",       32'(r_err),      32'd1);
    chk("f2_reqcnt",    32'(r_reqcnt),   32'd0);

    // Timeout: memory never acks
    access(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 0, 32'h1111_1111);
    chk("to_reqcnt",    32'(r_reqcnt),   32'd16);
    chk("to_done_cyc",  32'(r_done_cyc), 32'd18);
    chk("to_err",       32'(r_err),      32'd1);
    chk("to_ndone",     32'(r_ndone),    32'd1);

    // Late ack while idle has no effect
    mem_ack = 1'b1;
    tick();
    chk("late_done",    32'(cpu_done),   32'd0);
    tick();
    chk("late_req",     32'(mem_req),    32'd0);
    chk("late_done2",   32'(cpu_done),   32'd0);
    mem_ack = 1'b0;
    tick();

    // Next request accepted; ack in the last allowed REQ cycle succeeds
    access(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 16, 32'h1234_5678);
    chk("last_reqcnt",   32'(r_reqcnt),   32'd16);
    chk("last_done_cyc", 32'(r_done_cyc), 32'd18);
    chk("last_err",      32'(r_err),      32'd0);
    chk("last_rdata",    r_rdata,         32'h1234_5678);

    // Reset during the REQ wait
    chk("mr_ready", 32'(cpu_ready), 32'd1);
    cpu_valid = 1'b1;
    cpu_we    = 1'b0;
    cpu_size  = 2'b10;
    cpu_addr  = 32'h4;
    mem_rdata = 32'hABCD_0000;
    tick();
    cpu_valid = 1'b0;
    tick();
    tick();
    chk("mr_req_before", 32'(mem_req), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    chk("mr_req_after",  32'(mem_req),   32'd0);
    chk("mr_done",       32'(cpu_done),  32'd0);
    chk("mr_ready_rst",  32'(cpu_ready), 32'd0);
    mem_ack = 1'b1;
    tick();
    chk("mr_done2",      32'(cpu_done),  32'd0);
    mem_ack = 1'b0;
    rst = 1'b0;
    tick();
    chk("mr_ready_rel",  32'(cpu_ready), 32'd1);
    chk("mr_done3",      32'(cpu_done),  32'd0);

    // Normal access after reset
    access(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 1, 32'h0000_A500);
    chk("post_be",       32'(r_be),      32'h2);
    chk("post_rdata",    r_rdata,        32'h0000_00A5);
    chk("post_err",      32'(r_err),     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_master.md
# lsu_master

Load/store initiator that sits between the 32-bit core's execute stage and the data memory. It accepts one byte, halfword or word load/store from the core and drives a request/acknowledge handshake on the memory side. It returns aligned, sign- or zero-extended load data, or a completion flag for stores. It also enforces the memory's rules: word 0 is read-only, addresses must lie within ALENGTH words, and accesses must be aligned.

## Interface
- AWIDTH, 32: data and address width in bits.
- ALENGTH, 128: memory depth in words; a word index of ALENGTH or more is a fault.
- TIMEOUT, 16: maximum number of REQ cycles to wait for mem_ack.
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- cpu_valid  input  1  core request present.
- cpu_ready  output  1  block can accept a request (IDLE only).
- cpu_we  input  1  1 = store, 0 = load.
- cpu_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved (fault).
- cpu_signed  input  1  sign-extend load data.
- cpu_addr  input  AWIDTH  byte address.
- cpu_wdata  input  AWIDTH  store data, right-justified.
- cpu_done  output  1  one-cycle completion pulse.
- cpu_err  output  1  fault flag, valid with cpu_done.
- cpu_rdata  output  AWIDTH  load result, valid with cpu_done; 0 for stores and faults.
- mem_req  output  1  memory request; held until ack or timeout.
- mem_we  output  1  write strobe qualifying mem_req.
- mem_addr  output  AWIDTH  word index (cpu_addr >> 2).
- mem_be  output  4  byte enables; bit i selects bits 8i+7:8i.
- mem_wdata  output  AWIDTH  lane-replicated store data.
- mem_ack  input  1  memory accepted the request; mem_rdata is valid this cycle for loads.
- mem_rdata  input  AWIDTH  memory read word.

## Operation
- The FSM has four states: IDLE, CHECK, REQ and RESP.
- IDLE: cpu_ready = 1. When cpu_valid = 1, all cpu_* inputs are registered and the FSM moves to CHECK.
- CHECK (one cycle): the fault condition is evaluated on the registered request. A fault is any of:
  - size 11;
  - half with addr[0] = 1;
  - word with addr[1:0] != 00;
  - word index >= ALENGTH;
  - a store with word index 0.
- A fault sends the FSM to RESP with err = 1 and no mem_req. Otherwise the FSM goes to REQ.
- REQ: mem_req = 1, with mem_we, mem_addr, mem_be and mem_wdata held stable.
  - On mem_ack: capture mem_rdata (loads), then go to RESP with err = 0.
  - If the timeout counter reaches TIMEOUT without an ack: drop mem_req, go to RESP with err = 1.
- RESP: cpu_done = 1 for exactly one cycle, then the FSM returns to IDLE.
- Byte enables:
  - byte: 0001 << addr[1:0];
  - half: 0011 << addr[1:0];
  - word: 1111.
- Store data: byte replicated across all four lanes; half replicated across both halves; word unchanged.
- Load data (little-endian): shift = mem_rdata >> (8 × addr[1:0]), keep the low 8 or 16 bits, then sign- or zero-extend to 32 bits according to cpu_signed.
- An mem_ack arriving outside REQ is ignored.

## Timing
- Reset (rst sampled high): state = IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, cpu_done, cpu_err and cpu_rdata all = 0; timeout counter = 0. cpu_ready = 0 while rst = 1 and 1 from the first cycle after release.
- Cycle numbering for a good access, where cycle 0 is the accept edge:
  - cycle 1 = CHECK;
  - cycle 2 = first mem_req cycle;
  - with a same-cycle ack, cpu_done appears in cycle 3. This is the minimum latency of 3 cycles.
- Each cycle of ack delay adds one cycle of latency.
- Fault latency: cpu_done appears in cycle 2, and mem_req is never asserted.
- Timeout: mem_req is high for exactly TIMEOUT cycles, then deasserts. cpu_done with err = 1 follows on the next cycle.
- An ack in the final allowed REQ cycle counts as success.
- Reset mid-transaction: mem_req drops on the cycle after rst is sampled high, and no cpu_done is produced.
- cpu_valid outside IDLE is ignored. There is no queueing; the core must hold its request until cpu_ready is seen.

## Test plan
- Word store 0xDEADBEEF to addr 0x10, memory acks on the first REQ cycle → mem_addr = 4, mem_be = 1111, cpu_done in cycle 3, err = 0.
- Signed byte load from addr 0x13, mem_rdata = 0x80FF_0000 → mem_be = 1000, cpu_rdata = 0xFFFF_FF80; the same access with cpu_signed = 0 → 0x0000_0080.
- Half store 0x1234 to addr 0x06 → mem_be = 1100, mem_wdata = 0x1234_1234.
- Faults, each giving cpu_err = 1 in cycle 2 with mem_req never high:
  - store to addr 0x0;
  - word load at addr 0x2;
  - load at addr 0x200 (word index 128).
- Memory never acks → mem_req high for 16 cycles, then cpu_done with err = 1. A late ack afterwards has no effect, and the next request is accepted normally.
- rst asserted during the REQ wait (ack delayed 5 cycles) → mem_req = 0 the next cycle, no cpu_done, cpu_ready = 1 after release.
